imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_array.sv | 25 ++
 rtl/imem_responder.sv | 102 ++++++++++
 tb/tb_imem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] RV32I_NOP          = 32'h0000_0013;
    localparam int          IMEM_DEPTH_DEFAULT = 256;

    // Misaligned, or word index beyond the 2**aw-entry array.
    function automatic logic fetch_fault(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (2 + aw)) != 32'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction word storage, one sync write port, one write-first read port
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents survive reset so a loaded program persists.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding instruction fetch responder with fixed added latency
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH       = IMEM_DEPTH_DEFAULT,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_WORD    = RV32I_NOP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              iaddr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              idata,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int AW = $clog2(DEPTH);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_idata;
    logic          r_err;

    logic [31:0]   w_rd_addr;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_data;
    logic          w_fault;
    logic [31:0]   w_word;

    // In IDLE the read uses the live address so a zero-wait fetch reads on its accept edge.
    assign w_rd_addr = (r_state == ST_IDLE) ? iaddr : r_addr;
    assign w_idx     = w_rd_addr[2 +: AW];
    assign w_fault   = fetch_fault(w_rd_addr, AW);
    assign w_word    = w_fault ? ERR_WORD : w_rd_data;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (ld_en),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (w_idx),
        .o_rdata (w_rd_data)
    );

    assign req_ready = reset && (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign idata     = r_idata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_idata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_addr <= iaddr;
                        if (WAIT_CYCLES == 0) begin
                            r_idata <= w_word;
                            r_err   <= w_fault;
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_idata <= w_word;
                        r_err   <= w_fault;
                        r_cnt   <= 4'd0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized and directed checks of two responder builds against a transaction model
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic          ld_en     = 1'b0;
    logic [31:0]   iaddr     = 32'd0;
    logic [31:0]   ld_data   = 32'd0;
    logic [AW-1:0] ld_addr   = '0;

    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic [31:0] dat [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .iaddr(iaddr), .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .idata(dat[0]),
        .rsp_err(err[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .iaddr(iaddr), .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .idata(dat[1]),
        .rsp_err(err[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a fetch is outstanding from its accept edge until its handshake;
    // its word is looked up on edge accept+latency, after that edge's load.
    logic [31:0] mem_m  [DEPTH];
    bit          pend   [2];
    int          acc    [2];
    logic [31:0] addr_m [2];
    logic [31:0] data_m [2];
    logic        err_m  [2];
    int          e      = 0;
    bit          chk_en = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                pend[d]   = 0;
                data_m[d] = 32'd0;
                err_m[d]  = 1'b0;
            end
        end else begin
            e++;
            if (ld_en) mem_m[ld_addr] = ld_data;
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && (e - 1 >= acc[d] + wc(d)) && rsp_ready) begin
                    pend[d] = 0;
                end else if (!pend[d] && req_valid) begin
                    pend[d]   = 1;
                    acc[d]    = e;
                    addr_m[d] = iaddr;
                end
                if (pend[d] && (e == acc[d] + wc(d))) begin
                    if ((addr_m[d] % 4 != 0) || (addr_m[d] / 4 >= DEPTH)) begin
                        data_m[d] = NOP;
                        err_m[d]  = 1'b1;
                    end else begin
                        data_m[d] = mem_m[addr_m[d] / 4];
                        err_m[d]  = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                bit exp_v;
                exp_v = pend[d] && (e >= acc[d] + wc(d));
                chk($sformatf("model_rdy_w%0d", wc(d)), {31'd0, rdy[d]}, {31'd0, rst_n && !pend[d]});
                chk($sformatf("model_vld_w%0d", wc(d)), {31'd0, vld[d]}, {31'd0, exp_v});
                if (exp_v || !rst_n) begin
                    chk($sformatf("model_data_w%0d", wc(d)), dat[d], data_m[d]);
                    chk($sformatf("model_err_w%0d", wc(d)), {31'd0, err[d]}, {31'd0, err_m[d]});
                end
            end
        end
    end

    // Directed fetch with both builds idle and rsp_ready high: zero-wait build responds
    // one edge after accept, one-wait build two edges after.
    task automatic fetch(input logic [31:0] a, input logic [31:0] w, input logic ex, input string nm);
        chk({nm, "_rdy_before_w1"}, {31'd0, rdy[0]}, 32'd1);
        chk({nm, "_rdy_before_w0"}, {31'd0, rdy[1]}, 32'd1);
        req_valid = 1'b1;
        iaddr     = a;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, "_w0_vld_lat1"}, {31'd0, vld[1]}, 32'd1);
        chk({nm, "_w0_data"}, dat[1], w);
        chk({nm, "_w0_err"}, {31'd0, err[1]}, {31'd0, ex});
        chk({nm, "_w1_vld_lat1"}, {31'd0, vld[0]}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_w1_vld_lat2"}, {31'd0, vld[0]}, 32'd1);
        chk({nm, "_w1_data"}, dat[0], w);
        chk({nm, "_w1_err"}, {31'd0, err[0]}, {31'd0, ex});
        @(posedge clk); #1;
        chk({nm, "_w1_rdy_after"}, {31'd0, rdy[0]}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (r == 7) return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        else if (r == 8) return 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
        else             return $urandom;
    endfunction

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h00500F93;
        prog[1] = 32'h001F8F93;
        prog[2] = 32'h00000013;
        prog[3] = 32'hFE000EE3;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rdy", {31'd0, rdy[d]}, 32'd0);
            chk("reset_vld", {31'd0, vld[d]}, 32'd0);
            chk("reset_data", dat[d], 32'd0);
            chk("reset_err", {31'd0, err[d]}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("release_rdy_w1", {31'd0, rdy[0]}, 32'd1);
        chk("release_rdy_w0", {31'd0, rdy[1]}, 32'd1);
        chk_en = 1;

        for (int i = 0; i < DEPTH; i++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = (i < 4) ? prog[i] : $urandom;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        for (int i = 0; i < 4; i++) fetch(32'(4 * i), prog[i], 1'b0, $sformatf("prog%0d", i));
        fetch(32'h6, NOP, 1'b1, "misaligned");
        fetch(32'(4 * DEPTH), NOP, 1'b1, "out_of_range");

        // Response held off for five cycles.
        req_valid = 1'b1;
        iaddr     = 32'h4;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            for (int d = 0; d < 2; d++) begin
                chk("hold_vld", {31'd0, vld[d]}, 32'd1);
                chk("hold_data", dat[d], 32'h001F8F93);
                chk("hold_rdy", {31'd0, rdy[d]}, 32'd0);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("hold_release_rdy", {31'd0, rdy[d]}, 32'd1);
            chk("hold_release_vld", {31'd0, vld[d]}, 32'd0);
        end

        // Load colliding with the one-wait read edge, then a load while responding.
        req_valid = 1'b1;
        iaddr     = 32'h8;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ld_en     = 1'b1;
        ld_addr   = AW'(2);
        ld_data   = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("wfirst_w1", dat[0], 32'hDEADBEEF);
        chk("wfirst_w0_old", dat[1], 32'h00000013);
        ld_data = 32'h12345678;
        @(posedge clk); #1;
        ld_en = 1'b0;
        chk("resp_load_w1", dat[0], 32'hDEADBEEF);
        chk("resp_load_w0", dat[1], 32'h00000013);
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Reset one cycle into the wait state.
        req_valid = 1'b1;
        iaddr     = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_vld", {31'd0, vld[d]}, 32'd0);
            chk("abort_rdy", {31'd0, rdy[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp_w1", {31'd0, vld[0]}, 32'd0);
            chk("abort_no_rsp_w0", {31'd0, vld[1]}, 32'd0);
        end
        fetch(32'h0, 32'h00500F93, 1'b0, "refetch0");

        for (int i = 0; i < 3000; i++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n     = 1'b0;
                ld_en     = 1'b0;
                req_valid = 1'b0;
            end else begin
                req_valid = ($urandom_range(0, 9) < 6);
                iaddr     = rand_addr();
                rsp_ready = $urandom_range(0, 1) == 1;
                ld_en     = ($urandom_range(0, 3) == 0);
                ld_addr   = ($urandom_range(0, 1) == 1) ? addr_m[0][2 +: AW] : AW'($urandom_range(0, DEPTH - 1));
                ld_data   = $urandom;
            end
            @(posedge clk); #1;
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        ld_en     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
